stage_3: RTL and testbench

- Final arithmetic stage of the Q15 entropy encoder. Sits directly downstream of stage_2 and consumes its normalized range, shift count d, u, pre_low and control flags.
- Updates the low/cnt state and returns the registered range to stage 1 as feedback.
- Emits up to two 9-bit pre-bitstream words per cycle (bit 8 = carry) to the carry-propagation stage.
- Runs an end-of-frame flush FSM that drains the remaining low bits.

---
 rtl/stage_3_pkg.sv | 29 ++
 rtl/stage_3_low_norm.sv | 70 +++++++
 rtl/stage_3.sv | 151 +++++++++++++++
 tb/tb_stage_3.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/stage_3_pkg.sv
// rtl/stage_3_pkg.sv - shared constants, flag encodings and FSM states for stage_3
package stage_3_pkg;

    localparam int RANGE_WIDTH = 16;
    localparam int LOW_WIDTH   = 24;
    localparam int D_SIZE      = 5;
    localparam int CNT_WIDTH   = 6;
    localparam int OUT_WIDTH   = 9;
    localparam int E_WIDTH     = LOW_WIDTH + 1;

    localparam logic signed [CNT_WIDTH-1:0] CNT_INIT   = -6'sd9;
    localparam logic [RANGE_WIDTH-1:0]      RANGE_INIT = 16'h8000;
    localparam logic [31:0]                 FLUSH_MASK = 32'h0000_3FFF;

    localparam logic [1:0] FLAG_NONE = 2'b00;
    localparam logic [1:0] FLAG_ONE  = 2'b01;
    localparam logic [1:0] FLAG_TWO  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    function automatic logic [31:0] low_mask(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/stage_3_low_norm.sv
// rtl/stage_3_low_norm.sv - combinational low add, normalize and word extraction
module s3_low_norm
    import stage_3_pkg::*;
(
    input  logic [LOW_WIDTH-1:0]          low,
    input  logic signed [CNT_WIDTH-1:0]   cnt,
    input  logic [RANGE_WIDTH-1:0]        initial_range,
    input  logic [RANGE_WIDTH-1:0]        u_lo,
    input  logic [RANGE_WIDTH-1:0]        pre_low,
    input  logic [D_SIZE-1:0]             d,
    input  logic                          comp_mux_1,
    input  logic                          bool_flag,
    input  logic                          symbol,
    output logic [LOW_WIDTH-1:0]          low_next,
    output logic signed [CNT_WIDTH-1:0]   cnt_next,
    output logic [OUT_WIDTH-1:0]          word1,
    output logic [OUT_WIDTH-1:0]          word2,
    output logic [1:0]                    flag
);

    logic [31:0] add;
    logic [31:0] l;
    int          c;
    int          s;
    int          cp;

    always_comb begin
        add      = 32'd0;
        l        = 32'd0;
        c        = int'(cnt);
        s        = 0;
        cp       = 0;
        word1    = '0;
        word2    = '0;
        flag     = FLAG_NONE;
        low_next = '0;
        cnt_next = '0;

        if (bool_flag) begin
            add = symbol ? {16'd0, pre_low} : 32'd0;
        end else if (comp_mux_1) begin
            add = {16'd0, initial_range - u_lo};
        end

        l = {8'd0, low} + add;
        s = c + int'(d);

        if (s < 0) begin
            low_next = LOW_WIDTH'(l << d);
            cnt_next = CNT_WIDTH'(s);
        end else begin
            // cp is the bit position just above the bits that stay in low
            cp = c + 16;
            if (s >= 8) begin
                word1 = OUT_WIDTH'(l >> cp);
                l     = l & low_mask(cp);
                cp    = cp - 8;
                word2 = OUT_WIDTH'(l >> cp);
                flag  = FLAG_TWO;
            end else begin
                word1 = OUT_WIDTH'(l >> cp);
                flag  = FLAG_ONE;
            end
            l        = l & low_mask(cp);
            cnt_next = CNT_WIDTH'(cp + int'(d) - 24);
            low_next = LOW_WIDTH'(l << d);
        end
    end

endmodule

// File: rtl/stage_3.sv
// rtl/stage_3.sv - final encoder stage: low/cnt state, word emission and end-of-frame flush
module stage_3
    import stage_3_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [RANGE_WIDTH-1:0]  initial_range,
    input  logic [RANGE_WIDTH:0]    u,
    input  logic [RANGE_WIDTH-1:0]  pre_low,
    input  logic [RANGE_WIDTH-1:0]  in_range,
    input  logic [D_SIZE-1:0]       in_d,
    input  logic                    comp_mux_1,
    input  logic                    bool_flag,
    input  logic                    symbol,
    input  logic                    flush,
    output logic [RANGE_WIDTH-1:0]  range,
    output logic [OUT_WIDTH-1:0]    out_bit_1,
    output logic [OUT_WIDTH-1:0]    out_bit_2,
    output logic [1:0]              out_flag,
    output logic                    flush_done
);

    state_t                        state_q, state_d;
    logic [LOW_WIDTH-1:0]          low_q, low_d, low_upd;
    logic signed [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_upd;
    logic [RANGE_WIDTH-1:0]        range_q, range_d;
    logic [OUT_WIDTH-1:0]          out_bit_1_q, out_bit_1_d;
    logic [OUT_WIDTH-1:0]          out_bit_2_q, out_bit_2_d;
    logic [1:0]                    out_flag_q, out_flag_d;
    logic                          flush_done_q, flush_done_d;
    logic [E_WIDTH-1:0]            e_q, e_d;
    logic signed [CNT_WIDTH-1:0]   fc_q, fc_d, fs_q, fs_d, fs_dec;
    int                            sh;

    logic [LOW_WIDTH-1:0]          norm_low;
    logic signed [CNT_WIDTH-1:0]   norm_cnt;
    logic [OUT_WIDTH-1:0]          norm_w1, norm_w2;
    logic [1:0]                    norm_flag;
    logic                          unused_u_msb;

    assign unused_u_msb = u[RANGE_WIDTH];

    s3_low_norm u_low_norm (
        .low           (low_q),
        .cnt           (cnt_q),
        .initial_range (initial_range),
        .u_lo          (u[RANGE_WIDTH-1:0]),
        .pre_low       (pre_low),
        .d             (in_d),
        .comp_mux_1    (comp_mux_1),
        .bool_flag     (bool_flag),
        .symbol        (symbol),
        .low_next      (norm_low),
        .cnt_next      (norm_cnt),
        .word1         (norm_w1),
        .word2         (norm_w2),
        .flag          (norm_flag)
    );

    always_comb begin
        state_d      = state_q;
        low_d        = low_q;
        cnt_d        = cnt_q;
        range_d      = range_q;
        out_bit_1_d  = out_bit_1_q;
        out_bit_2_d  = out_bit_2_q;
        out_flag_d   = FLAG_NONE;
        flush_done_d = 1'b0;
        e_d          = e_q;
        fc_d         = fc_q;
        fs_d         = fs_q;
        low_upd      = low_q;
        cnt_upd      = cnt_q;
        fs_dec       = fs_q - 6'sd8;
        sh           = int'(fc_q) + 16;

        case (state_q)
            ST_RUN: begin
                if (in_valid) begin
                    low_upd    = norm_low;
                    cnt_upd    = norm_cnt;
                    range_d    = in_range;
                    out_flag_d = norm_flag;
                    if (norm_flag != FLAG_NONE) out_bit_1_d = norm_w1;
                    if (norm_flag == FLAG_TWO)  out_bit_2_d = norm_w2;
                end
                low_d = low_upd;
                cnt_d = cnt_upd;
                // flush snapshots the state after this cycle's symbol
                if (flush) begin
                    state_d = ST_FLUSH;
                    e_d     = E_WIDTH'(((32'(low_upd) + FLUSH_MASK) & ~FLUSH_MASK) | 32'h0000_4000);
                    fc_d    = cnt_upd;
                    fs_d    = cnt_upd + 6'sd10;
                end
            end
            ST_FLUSH: begin
                out_bit_1_d = OUT_WIDTH'(32'(e_q) >> sh);
                out_flag_d  = FLAG_ONE;
                e_d         = E_WIDTH'(32'(e_q) & low_mask(sh));
                fc_d        = fc_q - 6'sd8;
                fs_d        = fs_dec;
                if (fs_dec <= 6'sd0) state_d = ST_DONE;
            end
            ST_DONE: begin
                flush_done_d = 1'b1;
                low_d        = '0;
                cnt_d        = CNT_INIT;
                range_d      = RANGE_INIT;
                state_d      = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            low_q        <= '0;
            cnt_q        <= CNT_INIT;
            range_q      <= RANGE_INIT;
            out_bit_1_q  <= '0;
            out_bit_2_q  <= '0;
            out_flag_q   <= FLAG_NONE;
            flush_done_q <= 1'b0;
            e_q          <= '0;
            fc_q         <= '0;
            fs_q         <= '0;
        end else begin
            state_q      <= state_d;
            low_q        <= low_d;
            cnt_q        <= cnt_d;
            range_q      <= range_d;
            out_bit_1_q  <= out_bit_1_d;
            out_bit_2_q  <= out_bit_2_d;
            out_flag_q   <= out_flag_d;
            flush_done_q <= flush_done_d;
            e_q          <= e_d;
            fc_q         <= fc_d;
            fs_q         <= fs_d;
        end
    end

    assign range      = range_q;
    assign out_bit_1  = out_bit_1_q;
    assign out_bit_2  = out_bit_2_q;
    assign out_flag   = out_flag_q;
    assign flush_done = flush_done_q;

endmodule

// File: tb/tb_stage_3.sv
// tb/tb_stage_3.sv - directed self-checking bench for stage_3
module tb_stage_3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] initial_range = '0;
    logic [16:0] u = '0;
    logic [15:0] pre_low = '0;
    logic [15:0] in_range = '0;
    logic [4:0]  in_d = '0;
    logic        comp_mux_1 = 1'b0;
    logic        bool_flag = 1'b0;
    logic        symbol = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] rng_o;
    logic [8:0]  out_bit_1;
    logic [8:0]  out_bit_2;
    logic [1:0]  out_flag;
    logic        flush_done;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [5:0] CNT_M9 = 6'h37;
    localparam logic [5:0] CNT_M8 = 6'h38;
    localparam logic [5:0] CNT_M7 = 6'h39;
    localparam logic [5:0] CNT_M1 = 6'h3F;

    stage_3 dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .initial_range (initial_range),
        .u             (u),
        .pre_low       (pre_low),
        .in_range      (in_range),
        .in_d          (in_d),
        .comp_mux_1    (comp_mux_1),
        .bool_flag     (bool_flag),
        .symbol        (symbol),
        .flush         (flush),
        .range         (rng_o),
        .out_bit_1     (out_bit_1),
        .out_bit_2     (out_bit_2),
        .out_flag      (out_flag),
        .flush_done    (flush_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [5:0] exp);
        check(tag, {26'd0, dut.cnt_q}, {26'd0, exp});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0; flush = 1'b0; comp_mux_1 = 1'b0; bool_flag = 1'b0; symbol = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input logic iv, input logic [15:0] ir, input logic [16:0] uu,
                        input logic [15:0] pl, input logic [15:0] rng, input logic [4:0] d,
                        input logic cm, input logic bf, input logic sym, input logic fl);
        in_valid = iv; initial_range = ir; u = uu; pre_low = pl; in_range = rng;
        in_d = d; comp_mux_1 = cm; bool_flag = bf; symbol = sym; flush = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // reset state
        do_reset();
        check("rst_range", {16'd0, rng_o}, 32'h8000);
        check("rst_flag", {30'd0, out_flag}, 32'h0);
        check("rst_w1", {23'd0, out_bit_1}, 32'h0);
        check("rst_w2", {23'd0, out_bit_2}, 32'h0);
        check("rst_done", {31'd0, flush_done}, 32'h0);
        check("rst_low", {8'd0, dut.low_q}, 32'h0);
        check_cnt("rst_cnt", CNT_M9);

        // CDF symbol, no emission, then idle hold
        step(1, 16'd32768, 17'd20000, 16'd0, 16'd25000, 5'd1, 1, 0, 0, 0);
        check("cdf_low", {8'd0, dut.low_q}, 32'd25536);
        check_cnt("cdf_cnt", CNT_M8);
        check("cdf_flag", {30'd0, out_flag}, 32'h0);
        check("cdf_range", {16'd0, rng_o}, 32'd25000);
        step(0, 16'd1000, 17'd0, 16'd0, 16'd111, 5'd4, 1, 0, 0, 0);
        check("idle_range", {16'd0, rng_o}, 32'd25000);
        check("idle_low", {8'd0, dut.low_q}, 32'd25536);

        // boolean symbols
        do_reset();
        step(1, 16'd0, 17'd0, 16'd16380, 16'd30000, 5'd1, 0, 1, 1, 0);
        check("bool1_low", {8'd0, dut.low_q}, 32'd32760);
        check_cnt("bool1_cnt", CNT_M8);
        step(1, 16'd0, 17'd0, 16'd16380, 16'd30000, 5'd1, 1, 1, 0, 0);
        check("bool0_low", {8'd0, dut.low_q}, 32'd65520);
        check_cnt("bool0_cnt", CNT_M7);

        // single emit, no carry: reach low=0x7F8000 cnt=-1
        do_reset();
        step(1, 16'd32768, 17'd128, 16'd0, 16'd20000, 5'd8, 1, 0, 0, 0);
        check("pre1_low", {8'd0, dut.low_q}, 32'h7F8000);
        check_cnt("pre1_cnt", CNT_M1);
        step(1, 16'd0, 17'd0, 16'd0, 16'd20000, 5'd1, 0, 0, 0, 0);
        check("single_w1", {23'd0, out_bit_1}, 32'h0FF);
        check("single_flag", {30'd0, out_flag}, 32'h1);
        check("single_low", {8'd0, dut.low_q}, 32'h0);
        check_cnt("single_cnt", CNT_M8);

        // single emit with carry
        do_reset();
        step(1, 16'd40000, 17'd7104, 16'd0, 16'd20000, 5'd8, 1, 0, 0, 0);
        check("pre2_low", {8'd0, dut.low_q}, 32'h808000);
        step(1, 16'd0, 17'd0, 16'd0, 16'd20000, 5'd1, 0, 0, 0, 0);
        check("carry_w1", {23'd0, out_bit_1}, 32'h101);
        check("carry_flag", {30'd0, out_flag}, 32'h1);

        // double emit: reach low=0x2AB580 cnt=-1
        do_reset();
        step(1, 16'd0, 17'd0, 16'd0, 16'd20000, 5'd1, 0, 0, 0, 0);
        step(1, 16'd30000, 17'd8133, 16'd0, 16'd20000, 5'd7, 1, 0, 0, 0);
        check("pre3_low", {8'd0, dut.low_q}, 32'h2AB580);
        check_cnt("pre3_cnt", CNT_M1);
        step(1, 16'd0, 17'd0, 16'd0, 16'd20000, 5'd9, 0, 0, 0, 0);
        check("dbl_w1", {23'd0, out_bit_1}, 32'h055);
        check("dbl_w2", {23'd0, out_bit_2}, 32'h06B);
        check("dbl_flag", {30'd0, out_flag}, 32'h3);
        check("dbl_low", {8'd0, dut.low_q}, 32'h0);
        check_cnt("dbl_cnt", CNT_M8);

        // flush from reset-like state; symbol in the flush cycle is processed first
        do_reset();
        step(1, 16'd0, 17'd0, 16'd0, 16'd25000, 5'd0, 0, 0, 0, 1);
        check("fl0_range", {16'd0, rng_o}, 32'd25000);
        check("fl0_flag", {30'd0, out_flag}, 32'h0);
        step(1, 16'd100, 17'd0, 16'd0, 16'd11111, 5'd3, 1, 0, 0, 1);
        check("fl1_w1", {23'd0, out_bit_1}, 32'h080);
        check("fl1_flag", {30'd0, out_flag}, 32'h1);
        check("fl1_range", {16'd0, rng_o}, 32'd25000);
        check("fl1_done", {31'd0, flush_done}, 32'h0);
        step(1, 16'd100, 17'd0, 16'd0, 16'd11111, 5'd3, 1, 0, 0, 1);
        check("fl2_done", {31'd0, flush_done}, 32'h1);
        check("fl2_flag", {30'd0, out_flag}, 32'h0);
        check("fl2_range", {16'd0, rng_o}, 32'h8000);
        check("fl2_low", {8'd0, dut.low_q}, 32'h0);
        check_cnt("fl2_cnt", CNT_M9);
        step(0, 16'd0, 17'd0, 16'd0, 16'd0, 5'd0, 0, 0, 0, 0);
        check("fl3_done", {31'd0, flush_done}, 32'h0);

        // two-word flush from cnt=-1, low=0x7F8000
        do_reset();
        step(1, 16'd32768, 17'd128, 16'd0, 16'd20000, 5'd8, 1, 0, 0, 0);
        step(0, 16'd0, 17'd0, 16'd0, 16'd0, 5'd0, 0, 0, 0, 1);
        step(0, 16'd0, 17'd0, 16'd0, 16'd0, 5'd0, 0, 0, 0, 0);
        check("fl2w_a", {23'd0, out_bit_1}, 32'h0FF);
        check("fl2w_aflag", {30'd0, out_flag}, 32'h1);
        step(0, 16'd0, 17'd0, 16'd0, 16'd0, 5'd0, 0, 0, 0, 0);
        check("fl2w_b", {23'd0, out_bit_1}, 32'h080);
        check("fl2w_bdone", {31'd0, flush_done}, 32'h0);
        step(0, 16'd0, 17'd0, 16'd0, 16'd0, 5'd0, 0, 0, 0, 0);
        check("fl2w_done", {31'd0, flush_done}, 32'h1);

        // reset in the middle of a flush
        do_reset();
        step(1, 16'd32768, 17'd128, 16'd0, 16'd20000, 5'd8, 1, 0, 0, 0);
        step(1, 16'd0, 17'd0, 16'd0, 16'd20000, 5'd1, 0, 0, 0, 0);
        step(0, 16'd0, 17'd0, 16'd0, 16'd0, 5'd0, 0, 0, 0, 1);
        check("mid_hold_w1", {23'd0, out_bit_1}, 32'h0FF);
        flush = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_w1", {23'd0, out_bit_1}, 32'h0);
        check("mid_flag", {30'd0, out_flag}, 32'h0);
        check("mid_range", {16'd0, rng_o}, 32'h8000);
        @(negedge clk);
        reset = 1'b0;
        step(0, 16'd0, 17'd0, 16'd0, 16'd0, 5'd0, 0, 0, 0, 0);
        check("mid_done1", {31'd0, flush_done}, 32'h0);
        check("mid_flag1", {30'd0, out_flag}, 32'h0);
        step(0, 16'd0, 17'd0, 16'd0, 16'd0, 5'd0, 0, 0, 0, 0);
        check("mid_done2", {31'd0, flush_done}, 32'h0);
        check_cnt("mid_cnt", CNT_M9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
